// File: rtl/tlul_led_master.sv
// tlul_led_master: turns byte write/read requests into single-beat TL-UL Put/Get transactions to the LED slave.
module tlul_led_master #(
  parameter logic [31:0] LED_ADDR = 32'h0000_0000,
  parameter int SOURCE_W = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_write,
  input  logic [7:0]          i_req_data,
  output logic                o_rsp_valid,
  output logic [7:0]          o_rsp_data,
  output logic                o_rsp_error,
  output logic                o_a_valid,
  input  logic                i_a_ready,
  output logic [2:0]          o_a_opcode,
  output logic [2:0]          o_a_param,
  output logic [1:0]          o_a_size,
  output logic [SOURCE_W-1:0] o_a_source,
  output logic [31:0]         o_a_address,
  output logic [3:0]          o_a_mask,
  output logic [31:0]         o_a_data,
  input  logic                i_d_valid,
  output logic                o_d_ready,
  input  logic [2:0]          i_d_opcode,
  input  logic [SOURCE_W-1:0] i_d_source,
  input  logic [31:0]         i_d_data,
  input  logic                i_d_error
);
  typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, RSP} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [SOURCE_W-1:0] src;
  logic rd, err, timeout, unused_d;
  assign o_req_ready = state == IDLE;
  assign o_a_valid = state == A_SEND;
  assign o_rsp_valid = state == RSP;
  assign o_d_ready = state == IDLE || state == D_WAIT;
  assign o_a_param = 3'd0;
  assign o_a_size = 2'd2;
  assign o_a_mask = 4'hf;
  assign o_a_address = LED_ADDR;
  assign o_a_source = src;
  assign rd = o_a_opcode == 3'd4;
  assign err = i_d_error || i_d_source != src || i_d_opcode != {2'b00, rd};
  assign timeout = cnt == 16'(TIMEOUT - 1);
  assign unused_d = ^i_d_data[31:8];
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      src <= '0;
      o_a_opcode <= 3'd0;
      o_a_data <= 32'h0;
      o_rsp_data <= 8'h0;
      o_rsp_error <= 1'b0;
    end else case (state)
      IDLE: if (i_req_valid) begin
        o_a_opcode <= i_req_write ? 3'd0 : 3'd4;
        o_a_data <= i_req_write ? {24'h0, i_req_data} : 32'h0;
        state <= A_SEND;
      end
      A_SEND: if (i_a_ready) begin
        cnt <= '0;
        state <= D_WAIT;
      end
      D_WAIT: begin
        cnt <= cnt + 16'd1;
        if (i_d_valid) begin
          o_rsp_error <= err;
          o_rsp_data <= (rd && !err) ? i_d_data[7:0] : 8'h0;
          state <= RSP;
        end else if (timeout) begin
          o_rsp_error <= 1'b1;
          o_rsp_data <= 8'h0;
          state <= RSP;
        end
      end
      default: begin
        src <= src + SOURCE_W'(1);
        state <= IDLE;
      end
    endcase
endmodule

// File: tb/tb_tlul_led_master.sv
// tb_tlul_led_master: directed TL-UL transactions against a hand-driven slave with fixed expected results.
module tb_tlul_led_master;
  logic i_clk = 0, i_reset = 1;
  logic i_req_valid = 0, i_req_write = 0, i_a_ready = 0, i_d_valid = 0, i_d_error = 0;
  logic [7:0] i_req_data = 0;
  logic [2:0] i_d_opcode = 0;
  logic [1:0] i_d_source = 0;
  logic [31:0] i_d_data = 0;
  logic o_req_ready, o_rsp_valid, o_rsp_error, o_a_valid, o_d_ready;
  logic [7:0] o_rsp_data;
  logic [2:0] o_a_opcode, o_a_param;
  logic [1:0] o_a_size, o_a_source;
  logic [31:0] o_a_address, o_a_data;
  logic [3:0] o_a_mask;
  int n_chk = 0, n_pass = 0;

  tlul_led_master #(.LED_ADDR(32'h4000_0010), .SOURCE_W(2), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_error(o_rsp_error),
    .o_a_valid(o_a_valid), .i_a_ready(i_a_ready), .o_a_opcode(o_a_opcode), .o_a_param(o_a_param),
    .o_a_size(o_a_size), .o_a_source(o_a_source), .o_a_address(o_a_address), .o_a_mask(o_a_mask),
    .o_a_data(o_a_data),
    .i_d_valid(i_d_valid), .o_d_ready(o_d_ready), .i_d_opcode(i_d_opcode), .i_d_source(i_d_source),
    .i_d_data(i_d_data), .i_d_error(i_d_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic xact(input string t, input logic wr, input logic [7:0] b, input int stall,
                      input logic silent, input logic [2:0] dop, input logic [1:0] dsrc,
                      input logic [31:0] dd, input logic derr, input logic [1:0] xsrc,
                      input logic xerr, input logic [7:0] xdata, input int xwait);
    int w;
    chk({t, " req_ready idle"}, o_req_ready, 1);
    i_req_valid = 1; i_req_write = wr; i_req_data = b;
    tick;
    i_req_valid = 0; i_req_write = ~wr; i_req_data = ~b;
    for (int i = 0; i <= stall; i++) begin
      chk({t, " a_valid"}, o_a_valid, 1);
      chk({t, " a_opcode"}, o_a_opcode, wr ? 3'd0 : 3'd4);
      chk({t, " a_data"}, o_a_data, wr ? {24'h0, b} : 32'h0);
      chk({t, " a_source"}, o_a_source, xsrc);
      chk({t, " req_ready busy"}, o_req_ready, 0);
      if (i == 0) begin
        chk({t, " a_mask"}, o_a_mask, 4'hf);
        chk({t, " a_size"}, o_a_size, 2);
        chk({t, " a_param"}, o_a_param, 0);
        chk({t, " a_address"}, o_a_address, 32'h4000_0010);
      end
      i_a_ready = i == stall;
      tick;
    end
    i_a_ready = 0;
    w = 0;
    while (!o_rsp_valid && w < 20) begin
      w++;
      if (w == 1) begin
        chk({t, " d_ready"}, o_d_ready, 1);
        chk({t, " a_valid dropped"}, o_a_valid, 0);
      end
      i_d_valid = !silent && w == 1;
      i_d_opcode = dop; i_d_source = dsrc; i_d_data = dd; i_d_error = derr;
      tick;
      i_d_valid = 0;
    end
    chk({t, " rsp_valid"}, o_rsp_valid, 1);
    chk({t, " wait"}, w, xwait);
    chk({t, " rsp_error"}, o_rsp_error, xerr);
    chk({t, " rsp_data"}, o_rsp_data, xdata);
    tick;
    chk({t, " rsp one cycle"}, o_rsp_valid, 0);
    chk({t, " req_ready back"}, o_req_ready, 1);
  endtask

  initial begin
    tick; tick;
    chk("reset req_ready", o_req_ready, 1);
    chk("reset d_ready", o_d_ready, 1);
    chk("reset a_valid", o_a_valid, 0);
    chk("reset rsp_valid", o_rsp_valid, 0);
    chk("reset rsp_data", o_rsp_data, 0);
    chk("reset a_source", o_a_source, 0);
    i_reset = 0;
    tick;
    xact("wr_a5", 1, 8'ha5, 0, 0, 3'd0, 2'd0, 32'hdead_beef, 0, 2'd0, 0, 8'h00, 1);
    xact("rd_ok", 0, 8'h00, 0, 0, 3'd1, 2'd1, 32'h1234_5678, 0, 2'd1, 0, 8'h78, 1);
    xact("rd_badsrc", 0, 8'h00, 0, 0, 3'd1, 2'd3, 32'h0000_00ff, 0, 2'd2, 1, 8'h00, 1);
    xact("wr_stall", 1, 8'h3c, 5, 0, 3'd0, 2'd3, 32'h0, 0, 2'd3, 0, 8'h00, 1);
    xact("rd_ackop", 0, 8'h00, 0, 0, 3'd0, 2'd0, 32'h0000_0011, 0, 2'd0, 1, 8'h00, 1);
    xact("wr_timeout", 1, 8'h81, 0, 1, 3'd0, 2'd1, 32'h0, 0, 2'd1, 1, 8'h00, 4);
    i_d_valid = 1; i_d_opcode = 3'd0; i_d_source = 2'd1;
    chk("late d_ready", o_d_ready, 1);
    tick;
    i_d_valid = 0;
    for (int i = 0; i < 3; i++) chk("late no rsp", o_rsp_valid, 0);
    tick;
    chk("late still no rsp", o_rsp_valid, 0);
    xact("wr_ackdata", 1, 8'h22, 0, 0, 3'd1, 2'd2, 32'h0, 0, 2'd2, 1, 8'h00, 1);
    xact("rd_derr", 0, 8'h00, 0, 0, 3'd1, 2'd3, 32'h0000_0099, 1, 2'd3, 1, 8'h00, 1);
    xact("rd_5a", 0, 8'h00, 1, 0, 3'd1, 2'd0, 32'hffff_ff5a, 0, 2'd0, 0, 8'h5a, 1);
    i_req_valid = 1; i_req_write = 1; i_req_data = 8'h77;
    tick;
    i_req_valid = 0; i_a_ready = 1;
    tick;
    i_a_ready = 0;
    chk("pre-reset source", o_a_source, 1);
    #2 i_reset = 1;
    #1;
    chk("async a_valid", o_a_valid, 0);
    chk("async rsp_valid", o_rsp_valid, 0);
    chk("async req_ready", o_req_ready, 1);
    chk("async d_ready", o_d_ready, 1);
    chk("async rsp_data", o_rsp_data, 0);
    chk("async a_data", o_a_data, 0);
    chk("async a_source", o_a_source, 0);
    i_d_valid = 1; i_d_source = 2'd1;
    tick;
    chk("reset no rsp", o_rsp_valid, 0);
    i_d_valid = 0; i_reset = 0;
    tick;
    chk("post-reset no rsp", o_rsp_valid, 0);
    xact("rd_after_rst", 0, 8'h00, 0, 0, 3'd1, 2'd0, 32'h0000_00c3, 0, 2'd0, 0, 8'hc3, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
